// File: rtl/dma_complete_sched.sv
// dma_complete_sched
//   Turns DMA-complete counts posted by the PS into single-cycle completion pulses
//   for last_beat_calc. A pulse is never issued in a cycle where an address beat
//   could be accepted: the pulse cycle also raises o_addr_hold, which masks the
//   AW valid/ready pair between the AW snoop and last_beat_calc. If address
//   traffic keeps the channel busy for STARVE_LIMIT waiting cycles, the hold is
//   forced and counted in o_starve_count.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   i_cmpl_valid/count  PS completion post (count may be 0)
//   o_cmpl_ready        post accepted when valid && ready
//   i_up_valid          AW beat valid from the snoop
//   o_up_ready          ready back to the snoop (i_dn_ready masked by hold)
//   o_dn_valid          valid to last_beat_calc (i_up_valid masked by hold)
//   i_dn_ready          ready from last_beat_calc
//   i_pkt_outstanding   packets started but not yet completed (last_beat_calc)
//   o_dma_complete      one-cycle completion pulse
//   o_addr_hold         registered address-beat block, high with the pulse
//   o_pending           completions posted but not yet issued
//   o_starve_count      saturating count of forced holds
module dma_complete_sched #(
    parameter int CNT_W        = 3,
    parameter int PEND_W       = 6,
    parameter int PKT_W        = 3,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmpl_valid,
    input  logic [CNT_W-1:0]  i_cmpl_count,
    output logic              o_cmpl_ready,
    input  logic              i_up_valid,
    output logic              o_up_ready,
    output logic              o_dn_valid,
    input  logic              i_dn_ready,
    input  logic [PKT_W-1:0]  i_pkt_outstanding,
    output logic              o_dma_complete,
    output logic              o_addr_hold,
    output logic [PEND_W-1:0] o_pending,
    output logic [15:0]       o_starve_count
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    // Highest pending value that can still absorb a maximum-size post without wrapping.
    localparam logic [PEND_W-1:0] READY_MAX = PEND_W'((2 ** PEND_W) - (2 ** CNT_W));

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_FIRE    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt_next;
    logic [PEND_W-1:0]  r_pending;
    logic [PEND_W-1:0]  w_pending_next;
    logic [15:0]        r_starve;
    logic               r_hold;
    logic               r_cmpl;
    logic               w_accept;
    logic               w_issue;
    logic               w_eligible;
    logic               w_starve_inc;

    assign o_cmpl_ready = (r_pending <= READY_MAX);
    assign w_accept     = i_cmpl_valid && o_cmpl_ready;
    // The decrement lands at the end of the pulse cycle.
    assign w_issue      = (r_state == S_FIRE);
    // Holding issue until a packet has started keeps last_beat_calc from underflowing.
    assign w_eligible   = (r_pending != '0) && (i_pkt_outstanding != '0);

    always_comb begin
        w_pending_next = r_pending
                       + (w_accept ? PEND_W'(i_cmpl_count) : '0)
                       - (w_issue ? PEND_W'(1) : '0);
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_starve_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_eligible) begin
                    if (!i_up_valid) begin
                        w_state_next = S_FIRE;
                    end else begin
                        w_state_next    = S_WAIT;
                        w_wait_cnt_next = WAIT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (!w_eligible) begin
                    w_state_next = S_IDLE;
                end else if (!i_up_valid) begin
                    w_state_next = S_FIRE;
                end else if (r_wait_cnt == WAIT_W'(STARVE_LIMIT)) begin
                    // Address traffic never paused: steal a cycle anyway.
                    w_state_next = S_FIRE;
                    w_starve_inc = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
                end
            end
            S_FIRE: begin
                w_state_next = S_RECOVER;
            end
            S_RECOVER: begin
                // One unheld cycle so a stalled beat always gets through between pulses.
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_pending  <= '0;
            r_starve   <= '0;
            r_hold     <= 1'b0;
            r_cmpl     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_pending  <= w_pending_next;
            if (w_starve_inc && (r_starve != 16'hFFFF)) begin
                r_starve <= r_starve + 16'd1;
            end
            // Pulse and hold are registered copies of "entering FIRE".
            r_hold <= (w_state_next == S_FIRE);
            r_cmpl <= (w_state_next == S_FIRE);
        end
    end

    assign o_addr_hold    = r_hold;
    assign o_dma_complete = r_cmpl;
    assign o_pending      = r_pending;
    assign o_starve_count = r_starve;
    assign o_up_ready     = i_dn_ready && !r_hold;
    assign o_dn_valid     = i_up_valid && !r_hold;

endmodule

// File: tb/tb_dma_complete_sched.sv
module tb_dma_complete_sched;

    localparam int CNT_W        = 3;
    localparam int PEND_W       = 6;
    localparam int PKT_W        = 3;
    localparam int STARVE_LIMIT = 16;
    localparam int READY_MAX    = (2 ** PEND_W) - (2 ** CNT_W);

    logic              clk;
    logic              reset;
    logic              i_cmpl_valid;
    logic [CNT_W-1:0]  i_cmpl_count;
    logic              o_cmpl_ready;
    logic              i_up_valid;
    logic              o_up_ready;
    logic              o_dn_valid;
    logic              i_dn_ready;
    logic [PKT_W-1:0]  i_pkt_outstanding;
    logic              o_dma_complete;
    logic              o_addr_hold;
    logic [PEND_W-1:0] o_pending;
    logic [15:0]       o_starve_count;

    int n_cmp = 0;
    int n_bad = 0;

    dma_complete_sched #(
        .CNT_W(CNT_W), .PEND_W(PEND_W), .PKT_W(PKT_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_cmpl_valid(i_cmpl_valid),
        .i_cmpl_count(i_cmpl_count),
        .o_cmpl_ready(o_cmpl_ready),
        .i_up_valid(i_up_valid),
        .o_up_ready(o_up_ready),
        .o_dn_valid(o_dn_valid),
        .i_dn_ready(i_dn_ready),
        .i_pkt_outstanding(i_pkt_outstanding),
        .o_dma_complete(o_dma_complete),
        .o_addr_hold(o_addr_hold),
        .o_pending(o_pending),
        .o_starve_count(o_starve_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, got no finish, want finish");
        $fatal(1, "timeout");
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (o_dma_complete) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        i_cmpl_valid      = 1'b0;
        i_cmpl_count      = '0;
        i_up_valid        = 1'b0;
        i_dn_ready        = 1'b0;
        i_pkt_outstanding = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        i_cmpl_valid      = 1'b0;
        i_cmpl_count      = '0;
        i_up_valid        = 1'b1;
        i_dn_ready        = 1'b1;
        i_pkt_outstanding = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (o_dma_complete !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", o_dma_complete); end
        n_cmp++; if (o_addr_hold !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %b want 0", o_addr_hold); end
        n_cmp++; if (o_pending !== '0) begin n_bad++; $display("FAIL reset_pending: got %0d want 0", o_pending); end
        n_cmp++; if (o_starve_count !== 16'd0) begin n_bad++; $display("FAIL reset_starve: got %0d want 0", o_starve_count); end
        n_cmp++; if (o_cmpl_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", o_cmpl_ready); end
        reset = 1'b0;
        i_up_valid = 1'b0;
        i_dn_ready = 1'b0;
    endtask

    task automatic test_single_issue();
        do_reset();
        i_cmpl_valid = 1'b1; i_cmpl_count = 3'd1; i_pkt_outstanding = 3'd1;
        cyc();
        i_cmpl_valid = 1'b0;
        n_cmp++; if (o_pending !== 6'd1) begin n_bad++; $display("FAIL single_pend1: got %0d want 1", o_pending); end
        n_cmp++; if (o_dma_complete !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", o_dma_complete); end
        cyc();
        n_cmp++; if (o_dma_complete !== 1'b1) begin n_bad++; $display("FAIL single_pulse: got %b want 1", o_dma_complete); end
        n_cmp++; if (o_addr_hold !== 1'b1) begin n_bad++; $display("FAIL single_hold: got %b want 1", o_addr_hold); end
        i_up_valid = 1'b1; i_dn_ready = 1'b1;
        #1;
        n_cmp++; if (o_dn_valid !== 1'b0) begin n_bad++; $display("FAIL single_dnv_held: got %b want 0", o_dn_valid); end
        n_cmp++; if (o_up_ready !== 1'b0) begin n_bad++; $display("FAIL single_upr_held: got %b want 0", o_up_ready); end
        cyc();
        n_cmp++; if (o_dma_complete !== 1'b0) begin n_bad++; $display("FAIL single_one_cycle: got %b want 0", o_dma_complete); end
        n_cmp++; if (o_addr_hold !== 1'b0) begin n_bad++; $display("FAIL single_recover_hold: got %b want 0", o_addr_hold); end
        n_cmp++; if (o_pending !== 6'd0) begin n_bad++; $display("FAIL single_pend0: got %0d want 0", o_pending); end
        n_cmp++; if (o_dn_valid !== 1'b1) begin n_bad++; $display("FAIL single_dnv_recover: got %b want 1", o_dn_valid); end
        i_up_valid = 1'b0; i_dn_ready = 1'b0; i_pkt_outstanding = '0;
    endtask

    task automatic test_starve();
        int lat;
        bit found;
        do_reset();
        i_cmpl_valid = 1'b1; i_cmpl_count = 3'd1; i_pkt_outstanding = 3'd1;
        i_up_valid = 1'b1; i_dn_ready = 1'b1;
        cyc();
        i_cmpl_valid = 1'b0;
        lat = 0; found = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (o_dma_complete) begin
                found = 1'b1; lat = k;
                break;
            end
            cyc();
        end
        // Post edge, one IDLE decision cycle, 16 WAIT cycles, then the pulse.
        n_cmp++; if (!found || lat != STARVE_LIMIT + 2) begin n_bad++; $display("FAIL starve_latency: got %0d (found=%0b) want %0d", lat, found, STARVE_LIMIT + 2); end
        n_cmp++; if (o_addr_hold !== 1'b1) begin n_bad++; $display("FAIL starve_hold: got %b want 1", o_addr_hold); end
        n_cmp++; if (o_starve_count !== 16'd1) begin n_bad++; $display("FAIL starve_count: got %0d want 1", o_starve_count); end
        n_cmp++; if ((o_dn_valid && i_dn_ready) !== 1'b0) begin n_bad++; $display("FAIL starve_no_beat: got %b want 0", o_dn_valid && i_dn_ready); end
        cyc();
        n_cmp++; if (o_pending !== 6'd0) begin n_bad++; $display("FAIL starve_pend: got %0d want 0", o_pending); end
        n_cmp++; if (o_dn_valid !== 1'b1) begin n_bad++; $display("FAIL starve_recover_beat: got %b want 1", o_dn_valid); end
        i_up_valid = 1'b0; i_dn_ready = 1'b0; i_pkt_outstanding = '0;
    endtask

    task automatic test_outstanding_gate();
        int np;
        int last;
        int min_gap;
        do_reset();
        i_cmpl_valid = 1'b1; i_cmpl_count = 3'd3; i_pkt_outstanding = 3'd0;
        cyc();
        i_cmpl_valid = 1'b0;
        np = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_dma_complete) np++;
            cyc();
        end
        n_cmp++; if (np != 0) begin n_bad++; $display("FAIL gate_no_pulse: got %0d pulses want 0", np); end
        n_cmp++; if (o_pending !== 6'd3) begin n_bad++; $display("FAIL gate_pend3: got %0d want 3", o_pending); end
        i_pkt_outstanding = 3'd2;
        np = 0; last = -100; min_gap = 1000;
        for (int k = 0; k < 30; k++) begin
            if (o_dma_complete) begin
                if (np > 0 && (k - last) < min_gap) min_gap = k - last;
                last = k;
                np++;
            end
            cyc();
        end
        n_cmp++; if (np != 3) begin n_bad++; $display("FAIL gate_pulses: got %0d want 3", np); end
        n_cmp++; if (min_gap < 3) begin n_bad++; $display("FAIL gate_spacing: got %0d want >=3", min_gap); end
        n_cmp++; if (o_pending !== 6'd0) begin n_bad++; $display("FAIL gate_pend0: got %0d want 0", o_pending); end
        i_pkt_outstanding = '0;
    endtask

    task automatic test_fill();
        bit ok;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            i_cmpl_valid = 1'b1; i_cmpl_count = 3'd7;
            n_cmp++; if (o_cmpl_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_%0d: got %b want 1", i, o_cmpl_ready); end
            cyc();
        end
        i_cmpl_valid = 1'b0;
        n_cmp++; if (o_pending !== 6'd56) begin n_bad++; $display("FAIL fill_pend56: got %0d want 56", o_pending); end
        n_cmp++; if (o_cmpl_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready56: got %b want 1", o_cmpl_ready); end
        i_cmpl_valid = 1'b1; i_cmpl_count = 3'd1;
        cyc();
        n_cmp++; if (o_pending !== 6'd57) begin n_bad++; $display("FAIL fill_pend57: got %0d want 57", o_pending); end
        n_cmp++; if (o_cmpl_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready57: got %b want 0", o_cmpl_ready); end
        i_cmpl_count = 3'd7;
        cyc();
        i_cmpl_valid = 1'b0;
        n_cmp++; if (o_pending !== 6'd57) begin n_bad++; $display("FAIL fill_refused: got %0d want 57", o_pending); end
        i_pkt_outstanding = 3'd1;
        wait_pulse(10, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fill_pulse: got none want pulse within 10 cycles"); end
        i_pkt_outstanding = '0;
        cyc();
        n_cmp++; if (o_pending !== 6'd56) begin n_bad++; $display("FAIL fill_drain56: got %0d want 56", o_pending); end
        n_cmp++; if (o_cmpl_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_back: got %b want 1", o_cmpl_ready); end
    endtask

    task automatic test_post_during_fire();
        bit ok;
        do_reset();
        i_cmpl_valid = 1'b1; i_cmpl_count = 3'd2;
        cyc();
        i_cmpl_valid = 1'b0;
        i_pkt_outstanding = 3'd1;
        wait_pulse(10, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL pf_pulse: got none want pulse within 10 cycles"); end
        i_cmpl_valid = 1'b1; i_cmpl_count = 3'd4;
        cyc();
        i_cmpl_valid = 1'b0; i_pkt_outstanding = '0;
        n_cmp++; if (o_pending !== 6'd5) begin n_bad++; $display("FAIL pf_pend5: got %0d want 5", o_pending); end
    endtask

    task automatic test_reset_during_fire();
        bit ok;
        int np;
        do_reset();
        i_cmpl_valid = 1'b1; i_cmpl_count = 3'd2; i_pkt_outstanding = 3'd1;
        cyc();
        i_cmpl_valid = 1'b0;
        wait_pulse(10, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rf_pulse: got none want pulse within 10 cycles"); end
        reset = 1'b1;
        #1;
        n_cmp++; if (o_dma_complete !== 1'b0) begin n_bad++; $display("FAIL rf_pulse_drop: got %b want 0", o_dma_complete); end
        n_cmp++; if (o_addr_hold !== 1'b0) begin n_bad++; $display("FAIL rf_hold_drop: got %b want 0", o_addr_hold); end
        n_cmp++; if (o_pending !== 6'd0) begin n_bad++; $display("FAIL rf_pend: got %0d want 0", o_pending); end
        cyc();
        reset = 1'b0;
        np = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (o_dma_complete) np++;
        end
        n_cmp++; if (np != 0) begin n_bad++; $display("FAIL rf_no_pulse: got %0d want 0", np); end
        n_cmp++; if (o_pending !== 6'd0) begin n_bad++; $display("FAIL rf_pend_after: got %0d want 0", o_pending); end
        i_pkt_outstanding = '0;
    endtask

    // Reference model: pending is plain arithmetic on accepted posts and issued pulses,
    // outstanding behaves like last_beat_calc (random starts, one retired per pulse),
    // and a forced hold is recognised as a pulse that follows a cycle with a beat presented.
    task automatic test_random();
        int  pend_m;
        int  outs_m;
        int  starve_m;
        int  run;
        int  last_pulse;
        int  post_pct;
        bit  prev_up;
        bit  burst;
        bit  ready_m;
        bit  pulse;
        do_reset();
        pend_m = 0; outs_m = 0; starve_m = 0; run = 0; last_pulse = -100;
        prev_up = 1'b0; burst = 1'b0;
        for (int cyc_i = 0; cyc_i < 2400; cyc_i++) begin
            if (cyc_i % 40 == 0) burst = ($urandom_range(0, 1) == 1);
            post_pct = (cyc_i < 1200) ? 40 : 10;
            i_cmpl_valid      = ($urandom_range(0, 99) < post_pct);
            i_cmpl_count      = CNT_W'($urandom_range(0, 7));
            i_up_valid        = burst ? 1'b1 : ($urandom_range(0, 1) == 1);
            i_dn_ready        = ($urandom_range(0, 1) == 1);
            i_pkt_outstanding = PKT_W'(outs_m);
            @(negedge clk);
            ready_m = (pend_m <= READY_MAX);
            pulse   = o_dma_complete;
            n_cmp++; if (o_cmpl_ready !== ready_m) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc_i, o_cmpl_ready, ready_m); end
            n_cmp++; if (o_pending !== PEND_W'(pend_m)) begin n_bad++; $display("FAIL rnd_pending@%0d: got %0d want %0d", cyc_i, o_pending, pend_m); end
            n_cmp++; if (o_addr_hold !== pulse) begin n_bad++; $display("FAIL rnd_hold@%0d: got %b want %b", cyc_i, o_addr_hold, pulse); end
            n_cmp++; if (o_dn_valid !== (i_up_valid && !pulse)) begin n_bad++; $display("FAIL rnd_dnvalid@%0d: got %b want %b", cyc_i, o_dn_valid, i_up_valid && !pulse); end
            n_cmp++; if (o_up_ready !== (i_dn_ready && !pulse)) begin n_bad++; $display("FAIL rnd_upready@%0d: got %b want %b", cyc_i, o_up_ready, i_dn_ready && !pulse); end
            if (pulse) begin
                n_cmp++; if (pend_m == 0 || outs_m == 0) begin n_bad++; $display("FAIL rnd_legal@%0d: got pending=%0d outstanding=%0d want both >0", cyc_i, pend_m, outs_m); end
                n_cmp++; if (cyc_i - last_pulse < 3) begin n_bad++; $display("FAIL rnd_spacing@%0d: got %0d want >=3", cyc_i, cyc_i - last_pulse); end
                last_pulse = cyc_i;
                if (prev_up && starve_m < 16'hFFFF) starve_m++;
                run = 0;
            end else if (pend_m > 0 && outs_m > 0) begin
                run++;
            end else begin
                run = 0;
            end
            n_cmp++; if (run > STARVE_LIMIT + 2) begin n_bad++; $display("FAIL rnd_latency@%0d: got %0d eligible cycles want <=%0d", cyc_i, run, STARVE_LIMIT + 2); end
            n_cmp++; if (o_starve_count !== 16'(starve_m)) begin n_bad++; $display("FAIL rnd_starve@%0d: got %0d want %0d", cyc_i, o_starve_count, starve_m); end
            if (i_cmpl_valid && ready_m) pend_m += int'(i_cmpl_count);
            if (pulse) begin
                pend_m--;
                outs_m--;
            end
            if (outs_m < 7 && $urandom_range(0, 99) < 20) outs_m++;
            prev_up = i_up_valid;
            @(posedge clk);
            #1;
        end
        i_cmpl_valid = 1'b0; i_up_valid = 1'b0; i_dn_ready = 1'b0; i_pkt_outstanding = '0;
    endtask

    initial begin
        reset             = 1'b1;
        i_cmpl_valid      = 1'b0;
        i_cmpl_count      = '0;
        i_up_valid        = 1'b0;
        i_dn_ready        = 1'b0;
        i_pkt_outstanding = '0;
        test_reset();
        test_single_issue();
        test_starve();
        test_outstanding_gate();
        test_fill();
        test_post_during_fire();
        test_reset_during_fire();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
